// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning pc and ir.
// Gates register-file and data-memory writes from the decoder's control outputs.
module instr_sequencer #(
   parameter int          PCW         = 10,
   parameter logic [8:0]  HALT_OP     = 9'b111111111,
   parameter int          MEM_TIMEOUT = 15,
   parameter int          CNTW        = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            start,
   output logic [PCW-1:0]  imem_addr,
   input  logic [8:0]      instr_in,
   output logic [8:0]      ir,
   input  logic            dec_branch,
   input  logic            dec_mem_rd,
   input  logic            dec_mem_wr,
   input  logic            dec_reg_write,
   input  logic            br_taken,
   input  logic [PCW-1:0]  br_target,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ready,
   output logic            reg_we,
   output logic [PCW-1:0]  pc,
   output logic            busy,
   output logic            halted,
   output logic            fault,
   output logic [CNTW-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;

   state_t          state_q, state_d;
   logic [PCW-1:0]  pc_q, pc_d;
   logic [PCW-1:0]  npc_q, npc_d;    // pc to commit when a memory instruction completes
   logic [8:0]      ir_q, ir_d;
   logic [CNTW-1:0] ret_q, ret_d;
   logic [7:0]      wcnt_q, wcnt_d;  // cycles spent in MEM without dmem_ready
   logic            st_q, st_d;      // pending memory op is a store
   logic [PCW-1:0]  br_pc;
   logic            retire;

   // Next pc if the current EXEC instruction completes; branch decision taken here
   assign br_pc = (dec_branch && br_taken) ? br_target : pc_q + PCW'(1);

   // State register and datapath registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         npc_q   <= '0;
         ir_q    <= '0;
         ret_q   <= '0;
         wcnt_q  <= '0;
         st_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         ir_q    <= ir_d;
         ret_q   <= ret_d;
         wcnt_q  <= wcnt_d;
         st_q    <= st_d;
      end
   end

   // Next-state logic, pc/ir/retire updates and write gating
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      ir_d    = ir_q;
      ret_d   = ret_q;
      wcnt_d  = wcnt_q;
      st_d    = st_q;
      reg_we  = 1'b0;
      retire  = 1'b0;
      case (state_q)
         S_IDLE, S_HALT, S_FAULT: begin
            if (start) begin
               pc_d    = '0;
               ret_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = instr_in;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (ir_q == HALT_OP) begin
               state_d = S_HALT;
            end else if (dec_mem_wr || dec_mem_rd) begin
               // store wins over load when both are flagged
               st_d    = dec_mem_wr;
               npc_d   = br_pc;
               wcnt_d  = '0;
               state_d = S_MEM;
            end else begin
               reg_we  = dec_reg_write;
               pc_d    = br_pc;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (st_q) begin
                  pc_d    = npc_q;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wcnt_q == 8'(MEM_TIMEOUT - 1)) begin
               // pc stays on the faulting instruction
               state_d = S_FAULT;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            pc_d    = npc_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
      if (retire && (ret_q != {CNTW{1'b1}}))
         ret_d = ret_q + CNTW'(1);
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign retired   = ret_q;
   assign dmem_req  = (state_q == S_MEM);
   assign dmem_we   = (state_q == S_MEM) && st_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM)   || (state_q == S_WB);
   assign halted    = (state_q == S_HALT);
   assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model with random programs,
// random branch outcomes and random data-memory latencies.
module tb_instr_sequencer;
   localparam logic [8:0] HALT = 9'h1FF;
   localparam int         TMO  = 15;

   logic        Clk = 1'b0;
   logic        Reset, start;
   logic [9:0]  imem_addr, br_target, pc;
   logic [8:0]  instr_in, ir;
   logic        dec_branch, dec_mem_rd, dec_mem_wr, dec_reg_write, br_taken;
   logic        dmem_req, dmem_we, dmem_ready, reg_we, busy, halted, fault;
   logic [15:0] retired;

   logic [8:0]  prog [1024];
   logic [9:0]  m_pc;
   int          m_ret;
   int          n_tests = 0;
   int          n_fail  = 0;

   instr_sequencer dut (
      .Clk(Clk), .Reset(Reset), .start(start), .imem_addr(imem_addr), .instr_in(instr_in),
      .ir(ir), .dec_branch(dec_branch), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
      .dec_reg_write(dec_reg_write), .br_taken(br_taken), .br_target(br_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .reg_we(reg_we),
      .pc(pc), .busy(busy), .halted(halted), .fault(fault), .retired(retired)
   );

   always #5 Clk = ~Clk;

   // Registered instruction memory: data valid the cycle after the address
   always @(posedge Clk) instr_in <= prog[imem_addr];

   // Toy decoder: op = ir[8:6]; ir[5] flags a branch; 5 = load, 6/7 = store (7 also load)
   assign dec_branch    = ir[5];
   assign dec_mem_rd    = (ir[8:6] == 3'd5) || (ir[8:6] == 3'd7);
   assign dec_mem_wr    = (ir[8:6] == 3'd6) || (ir[8:6] == 3'd7);
   assign dec_reg_write = ((ir[8:6] < 3'd4) && !ir[5]) || (ir[8:6] == 3'd5);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Run the instruction at m_pc from its FETCH cycle; called at posedge+1 of FETCH.
   // w = dmem latency in wait cycles (>= TMO means never ready).
   task automatic exec_one(input bit tk, input logic [9:0] tgt, input int w);
      logic [8:0] ins;
      logic [2:0] op;
      bit   is_halt, is_st, is_ld, is_mem, flt, alu_rw, exp_rw;
      int   len, nrw, first_rw, nreq, webad, exp_req;
      ins     = prog[m_pc];
      op      = ins[8:6];
      is_halt = (ins == HALT);
      is_st   = !is_halt && (op == 3'd6 || op == 3'd7);
      is_ld   = !is_halt && (op == 3'd5);
      is_mem  = is_st || is_ld;
      flt     = is_mem && (w >= TMO);
      alu_rw  = (op < 3'd4) && !ins[5];
      if (is_halt || (!is_mem))  len = 3;
      else if (flt)              len = 3 + TMO;
      else if (is_st)            len = 4 + w;
      else                       len = 5 + w;
      exp_rw  = !is_halt && !flt && !is_st && (is_ld || alu_rw);
      exp_req = flt ? TMO : (is_mem ? w + 1 : 0);
      br_taken = tk; br_target = tgt;
      nrw = 0; first_rw = 0; nreq = 0; webad = 0;
      for (int c = 1; c <= len; c++) begin
         dmem_ready = is_mem && !flt && (c == 4 + w);
         start      = is_halt && (c == 3);   // must be ignored outside IDLE/HALT/FAULT
         #1;
         if (c == 1) chk("imem_addr", imem_addr, m_pc);
         if (c == 3) chk("ir", ir, ins);
         if (reg_we) begin nrw++; if (first_rw == 0) first_rw = c; end
         if (dmem_req) begin nreq++; if (dmem_we !== is_st) webad++; end
         @(posedge Clk); #1;
      end
      dmem_ready = 1'b0; start = 1'b0;
      if (!is_halt && !flt) begin
         m_pc  = (ins[5] && tk) ? tgt : m_pc + 10'd1;
         m_ret = m_ret + 1;
      end
      chk("reg_we_count", nrw, exp_rw ? 1 : 0);
      if (exp_rw) chk("reg_we_cycle", first_rw, is_ld ? 5 + w : 3);
      chk("dmem_req_cycles", nreq, exp_req);
      chk("dmem_we", webad, 0);
      chk("pc", pc, m_pc);
      chk("retired", retired, m_ret);
      chk("busy", busy, !is_halt && !flt);
      chk("halted", halted, is_halt);
      chk("fault", fault, flt);
   endtask

   task automatic restart();
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      m_pc = '0; m_ret = 0;
      chk("restart_busy", busy, 1);
      chk("restart_pc", pc, 0);
      chk("restart_fault", fault, 0);
      chk("restart_halted", halted, 0);
      chk("restart_retired", retired, 0);
   endtask

   initial begin
      int r, w;
      for (int i = 0; i < 1024; i++) prog[i] = 9'h012;
      Reset = 1'b1; start = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0; br_target = '0;
      m_pc = '0; m_ret = 0;
      #23;
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_retired", retired, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {halted, fault, dmem_req, dmem_we, reg_we}, 0);
      @(negedge Clk); Reset = 1'b0;
      @(posedge Clk); #1;

      // Directed program
      prog[10'h000] = 9'h012;  // ALU, reg write
      prog[10'h001] = 9'h020;  // branch
      prog[10'h3F0] = 9'h020;
      prog[10'h3F1] = 9'h020;
      prog[10'h3FF] = 9'h012;
      prog[10'h010] = 9'h140;  // load
      prog[10'h011] = 9'h180;  // store
      prog[10'h012] = 9'h180;  // store that times out
      prog[10'h020] = HALT;
      restart();
      exec_one(0, 10'h000, 0);       // ALU: pc 0->1, reg_we in cycle 3
      exec_one(1, 10'h3F0, 0);       // taken branch
      exec_one(0, 10'h123, 0);       // not taken -> 3F1
      exec_one(1, 10'h3FF, 0);       // taken -> 3FF
      exec_one(0, 10'h000, 0);       // wrap to 0
      exec_one(0, 10'h000, 0);
      exec_one(1, 10'h010, 0);
      exec_one(0, 10'h000, 3);       // load, 3 wait cycles
      exec_one(0, 10'h000, 0);       // store, immediate ready
      exec_one(0, 10'h000, 40);      // store never ready -> FAULT at pc 0x12
      restart();
      exec_one(0, 10'h000, 0);
      exec_one(1, 10'h020, 0);
      exec_one(0, 10'h000, 0);       // HALT, start in EXEC ignored
      repeat (3) @(posedge Clk);
      #1;
      chk("halt_hold_pc", pc, m_pc);
      chk("halt_hold_retired", retired, m_ret);
      chk("halt_hold", halted, 1);

      // Random program
      for (int i = 0; i < 1024; i++) begin
         r = $urandom_range(0, 99);
         prog[i] = (r < 2) ? HALT : 9'($urandom_range(0, 510));
      end
      restart();
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         w = (r < 5) ? TMO + $urandom_range(0, 5) : $urandom_range(0, 4);
         exec_one(1'($urandom_range(0, 1)), 10'($urandom), w);
         if (halted || fault) restart();
      end

      // Reset in the middle of a load's MEM phase
      prog[m_pc] = 9'h140;
      repeat (4) begin @(posedge Clk); #1; end
      chk("pre_rst_req", dmem_req, 1);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_req", dmem_req, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_pc", pc, 0);
      chk("async_rst_flags", {halted, fault, reg_we}, 0);
      @(negedge Clk); Reset = 1'b0;
      @(posedge Clk); #1;
      chk("post_rst_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the 9-bit processor. It owns the program counter and the instruction register. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, and gates register-file and data-memory writes using the decoder's control outputs. It sits between instruction memory, the control decoder, the register file and a variable-latency data memory.

Parameters:
PCW, 10, program counter / instruction memory address width
HALT_OP, 9'b111111111, instruction encoding that stops the machine
MEM_TIMEOUT, 15, max cycles to wait for dmem_ready before fault (1..255)
CNTW, 16, retired-instruction counter width

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin execution from pc=0 (sampled in IDLE/HALT/FAULT)
imem_addr  out  PCW  instruction memory address (equals pc)
instr_in  in  9  instruction memory data; registered memory, valid the cycle after imem_addr
ir  out  9  instruction register, drives control decoder
dec_branch  in  1  decoder Branch, valid in EXEC
dec_mem_rd  in  1  decoder MemtoReg (load), valid in EXEC
dec_mem_wr  in  1  decoder MemWrite (store), valid in EXEC
dec_reg_write  in  1  decoder RegWrite, valid in EXEC
br_taken  in  1  datapath branch condition, valid in EXEC
br_target  in  PCW  branch/jump destination, valid in EXEC
dmem_req  out  1  data memory request, held until accepted
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_ready  in  1  data memory completion
reg_we  out  1  register file write enable (single-cycle pulse)
pc  out  PCW  current program counter
busy  out  1  high in FETCH/DECODE/EXEC/MEM/WB
halted  out  1  high in HALT
fault  out  1  high in FAULT
retired  out  CNTW  count of completed instructions, saturating

Behaviour:
- Reset (async) state: state=IDLE, pc=0, ir=0, retired=0; all other outputs 0. A reset mid-instruction aborts it with no write.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- IDLE/HALT/FAULT + start: pc<=0, retired<=0, go to FETCH. Otherwise hold. start is ignored in all other states.
- FETCH: imem_addr=pc. Next state is DECODE.
- DECODE: ir<=instr_in. Next state is EXEC.
- EXEC, evaluated in this priority order:
  - ir==HALT_OP: go to HALT. pc unchanged, no write, retired unchanged.
  - dec_mem_wr=1 (wins over dec_mem_rd): go to MEM with dmem_we=1.
  - dec_mem_rd=1: go to MEM with dmem_we=0.
  - Otherwise: reg_we=dec_reg_write this cycle, update pc, retired+1, go to FETCH.
- PC update: if dec_branch and br_taken, pc<=br_target; otherwise pc<=pc+1, wrapping mod 2^PCW. The branch decision is captured in EXEC for memory instructions.
- MEM:
  - dmem_req=1 every cycle in MEM.
  - The wait counter clears on entry and increments each cycle dmem_ready=0.
  - On dmem_ready=1: a store updates pc, retires and goes to FETCH; a load goes to WB.
  - If the counter reaches MEM_TIMEOUT with no ready: go to FAULT. pc is held (points at the faulting instruction) and there is no write.
  - dmem_ready outside MEM is ignored.
- WB: reg_we=1 for one cycle, update pc, retired+1, go to FETCH.
- Latency: ALU/branch instruction = 3 cycles. Store = 4 + wait cycles. Load = 5 + wait cycles. With ready in the first MEM cycle, wait cycles = 0.
- retired saturates at 2^CNTW-1.
- reg_we is never high outside EXEC and WB. dmem_req is never high outside MEM.

Test Plan:
- Reset mid-MEM with dmem_req=1 -> dmem_req, busy and pc drop to 0 in the same cycle without a clock; state IDLE; no reg_we.
- start; imem returns ALU op 9'h012, dec_reg_write=1 -> reg_we pulses exactly in cycle 3; pc 0->1; retired=1; FETCH again in cycle 4.
- Branch in EXEC with dec_branch=1, br_taken=1, br_target=10'h3F0 -> pc=3F0. Repeat with br_taken=0 -> pc=pc+1. At pc=10'h3FF non-branch -> pc wraps to 0.
- Load with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; WB reg_we pulse; instruction total 8 cycles. Store with immediate ready -> no reg_we; 4 cycles.
- dmem_ready held 0 -> fault=1 after exactly MEM_TIMEOUT=15 MEM cycles; pc unchanged; then start -> FETCH at pc=0, fault=0.
- ir=HALT_OP -> halted=1, pc and retired frozen; start while in EXEC is ignored; start in HALT restarts at pc=0.
